// File: rtl/vend_ctrl_if.sv
// Coin/selection/change handshake bundle between the vending front panel and vend_ctrl.
interface vend_ctrl_if;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       change_ack;
  logic [7:0] credit;
  logic       coin_reject;
  logic       price_short;
  logic       dispense;
  logic [1:0] dispense_id;
  logic       change_valid;
  logic [7:0] change_amt;
  logic       busy;

  modport master (
    output coin_valid, coin_code, sel_valid, sel, cancel, change_ack,
    input  credit, coin_reject, price_short, dispense, dispense_id,
           change_valid, change_amt, busy
  );

  modport slave (
    input  coin_valid, coin_code, sel_valid, sel, cancel, change_ack,
    output credit, coin_reject, price_short, dispense, dispense_id,
           change_valid, change_amt, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coins, vends on selection, returns change.
module vend_ctrl #(
  parameter int unsigned PRICE_A    = 25,
  parameter int unsigned PRICE_B    = 50,
  parameter int unsigned PRICE_C    = 75,
  parameter int unsigned PRICE_D    = 100,
  parameter int unsigned MAX_CREDIT = 200
) (
  input logic        clk,
  input logic        rst_n,
  vend_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  state_t state;

  logic [7:0] coin_val;
  logic [8:0] coin_sum;
  logic       coin_fits;
  logic [7:0] sel_price;
  logic [7:0] vend_price;
  logic [7:0] remainder;

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = 8'(PRICE_A);
      2'd1:    price_of = 8'(PRICE_B);
      2'd2:    price_of = 8'(PRICE_C);
      default: price_of = 8'(PRICE_D);
    endcase
  endfunction

  always_comb begin
    case (bus.coin_code)
      2'b00:   coin_val = 8'd5;
      2'b01:   coin_val = 8'd10;
      2'b10:   coin_val = 8'd25;
      default: coin_val = 8'd100;
    endcase
    // 9-bit sum so an overflowing coin is rejected instead of wrapping
    coin_sum   = {1'b0, bus.credit} + {1'b0, coin_val};
    coin_fits  = (coin_sum <= 9'(MAX_CREDIT));
    sel_price  = price_of(bus.sel);
    vend_price = price_of(bus.dispense_id);
    remainder  = bus.credit - vend_price;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.credit       <= '0;
      bus.change_amt   <= '0;
      bus.dispense_id  <= '0;
      bus.coin_reject  <= 1'b0;
      bus.price_short  <= 1'b0;
      bus.dispense     <= 1'b0;
      bus.change_valid <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.coin_reject <= 1'b0;
      bus.price_short <= 1'b0;
      bus.dispense    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cancel) begin
            bus.coin_reject <= bus.coin_valid;
          end else if (bus.sel_valid) begin
            bus.price_short <= 1'b1;
            bus.coin_reject <= bus.coin_valid;
          end else if (bus.coin_valid) begin
            if (coin_fits) begin
              bus.credit <= coin_sum[7:0];
              state      <= CREDIT;
            end else begin
              bus.coin_reject <= 1'b1;
            end
          end
        end
        CREDIT: begin
          if (bus.cancel) begin
            bus.coin_reject  <= bus.coin_valid;
            bus.change_valid <= 1'b1;
            bus.change_amt   <= bus.credit;
            bus.busy         <= 1'b1;
            state            <= CHANGE;
          end else if (bus.sel_valid) begin
            bus.coin_reject <= bus.coin_valid;
            if (bus.credit >= sel_price) begin
              bus.dispense    <= 1'b1;
              bus.dispense_id <= bus.sel;
              bus.busy        <= 1'b1;
              state           <= VEND;
            end else begin
              bus.price_short <= 1'b1;
            end
          end else if (bus.coin_valid) begin
            if (coin_fits) bus.credit <= coin_sum[7:0];
            else           bus.coin_reject <= 1'b1;
          end
        end
        VEND: begin
          bus.coin_reject <= bus.coin_valid;
          bus.credit      <= remainder;
          if (remainder != '0) begin
            bus.change_valid <= 1'b1;
            bus.change_amt   <= remainder;
            state            <= CHANGE;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        CHANGE: begin
          bus.coin_reject <= bus.coin_valid;
          if (bus.change_ack) begin
            bus.credit       <= '0;
            bus.change_valid <= 1'b0;
            bus.change_amt   <= '0;
            bus.busy         <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed, table-driven check of vend_ctrl plus hand-written reset-abort sequences.
module tb_vend_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vend_ctrl_if bus ();

  vend_ctrl #(
    .PRICE_A(25), .PRICE_B(50), .PRICE_C(75), .PRICE_D(100), .MAX_CREDIT(200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    logic       cv;
    logic [1:0] cc;
    logic       sv;
    logic [1:0] s;
    logic       cn;
    logic       ack;
    int unsigned e_credit;
    logic       e_rej;
    logic       e_short;
    logic       e_disp;
    int unsigned e_id;
    logic       e_cv;
    int unsigned e_amt;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic add(input logic cv, input logic [1:0] cc, input logic sv, input logic [1:0] s,
                     input logic cn, input logic ack, input int unsigned e_credit,
                     input logic e_rej, input logic e_short, input logic e_disp,
                     input int unsigned e_id, input logic e_cv, input int unsigned e_amt,
                     input logic e_busy);
    vec_t v;
    v.cv = cv; v.cc = cc; v.sv = sv; v.s = s; v.cn = cn; v.ack = ack;
    v.e_credit = e_credit; v.e_rej = e_rej; v.e_short = e_short; v.e_disp = e_disp;
    v.e_id = e_id; v.e_cv = e_cv; v.e_amt = e_amt; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " credit"},       bus.credit, 0);
    check({tag, " change_amt"},   bus.change_amt, 0);
    check({tag, " dispense_id"},  bus.dispense_id, 0);
    check({tag, " coin_reject"},  bus.coin_reject, 0);
    check({tag, " price_short"},  bus.price_short, 0);
    check({tag, " dispense"},     bus.dispense, 0);
    check({tag, " change_valid"}, bus.change_valid, 0);
    check({tag, " busy"},         bus.busy, 0);
  endtask

  task automatic drive(input logic cv, input logic [1:0] cc, input logic sv, input logic [1:0] s,
                       input logic cn, input logic ack);
    bus.coin_valid = cv; bus.coin_code = cc; bus.sel_valid = sv;
    bus.sel = s; bus.cancel = cn; bus.change_ack = ack;
  endtask

  initial begin
    // coin codes: 0=5 1=10 2=25 3=100
    //   cv cc   sv s    cn ack  credit rej shrt disp id cv  amt busy
    add(1, 2'd2, 0, 2'd0, 0, 0,  25,   0,  0,   0,   0, 0,  0,  0); // 25
    add(1, 2'd2, 0, 2'd0, 0, 0,  50,   0,  0,   0,   0, 0,  0,  0); // 50
    add(0, 2'd0, 1, 2'd1, 0, 0,  50,   0,  0,   1,   1, 0,  0,  1); // exact vend item 1
    add(0, 2'd0, 0, 2'd0, 0, 0,  0,    0,  0,   0,   0, 0,  0,  0); // back to IDLE
    add(1, 2'd3, 0, 2'd0, 0, 0,  100,  0,  0,   0,   0, 0,  0,  0); // 100
    add(0, 2'd0, 1, 2'd0, 0, 0,  100,  0,  0,   1,   0, 0,  0,  1); // vend item 0
    add(0, 2'd0, 0, 2'd0, 0, 0,  75,   0,  0,   0,   0, 1,  75, 1); // change 75
    add(1, 2'd2, 1, 2'd0, 0, 0,  75,   1,  0,   0,   0, 1,  75, 1); // busy lockout
    add(0, 2'd0, 0, 2'd0, 0, 1,  0,    0,  0,   0,   0, 0,  0,  0); // ack
    add(0, 2'd0, 0, 2'd0, 0, 1,  0,    0,  0,   0,   0, 0,  0,  0); // stray ack ignored
    add(1, 2'd1, 0, 2'd0, 0, 0,  10,   0,  0,   0,   0, 0,  0,  0); // 10
    add(0, 2'd0, 1, 2'd3, 0, 0,  10,   0,  1,   0,   0, 0,  0,  0); // short for 100
    add(0, 2'd0, 0, 2'd0, 0, 0,  10,   0,  0,   0,   0, 0,  0,  0); // pulse cleared
    add(0, 2'd0, 0, 2'd0, 1, 0,  10,   0,  0,   0,   0, 1,  10, 1); // cancel -> refund
    add(0, 2'd0, 0, 2'd0, 0, 1,  0,    0,  0,   0,   0, 0,  0,  0);
    add(0, 2'd0, 1, 2'd0, 0, 0,  0,    0,  1,   0,   0, 0,  0,  0); // sel in IDLE
    add(1, 2'd3, 0, 2'd0, 0, 0,  100,  0,  0,   0,   0, 0,  0,  0);
    add(1, 2'd3, 0, 2'd0, 0, 0,  200,  0,  0,   0,   0, 0,  0,  0); // reaches MAX exactly
    add(1, 2'd0, 0, 2'd0, 0, 0,  200,  1,  0,   0,   0, 0,  0,  0); // 5 overflows
    add(0, 2'd0, 0, 2'd0, 1, 0,  200,  0,  0,   0,   0, 1,  200,1);
    add(0, 2'd0, 0, 2'd0, 0, 1,  0,    0,  0,   0,   0, 0,  0,  0);
    add(1, 2'd2, 0, 2'd0, 0, 0,  25,   0,  0,   0,   0, 0,  0,  0);
    add(1, 2'd2, 0, 2'd0, 0, 0,  50,   0,  0,   0,   0, 0,  0,  0);
    add(1, 2'd2, 1, 2'd0, 1, 0,  50,   1,  0,   0,   0, 1,  50, 1); // cancel+sel+coin
    add(0, 2'd0, 0, 2'd0, 0, 1,  0,    0,  0,   0,   0, 0,  0,  0);
    add(1, 2'd1, 1, 2'd0, 0, 0,  0,    1,  1,   0,   0, 0,  0,  0); // sel+coin in IDLE
    add(1, 2'd2, 0, 2'd0, 0, 0,  25,   0,  0,   0,   0, 0,  0,  0);
    add(0, 2'd0, 1, 2'd2, 0, 0,  25,   0,  1,   0,   0, 0,  0,  0); // 25 < 75

    rst_n = 1'b0;
    drive(0, 2'd0, 0, 2'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].cv, vecs[i].cc, vecs[i].sv, vecs[i].s, vecs[i].cn, vecs[i].ack);
      @(posedge clk);
      #1;
      check($sformatf("v%0d credit", i),       bus.credit,       vecs[i].e_credit);
      check($sformatf("v%0d coin_reject", i),  bus.coin_reject,  vecs[i].e_rej);
      check($sformatf("v%0d price_short", i),  bus.price_short,  vecs[i].e_short);
      check($sformatf("v%0d dispense", i),     bus.dispense,     vecs[i].e_disp);
      check($sformatf("v%0d change_valid", i), bus.change_valid, vecs[i].e_cv);
      check($sformatf("v%0d busy", i),         bus.busy,         vecs[i].e_busy);
      if (vecs[i].e_disp)
        check($sformatf("v%0d dispense_id", i), bus.dispense_id, vecs[i].e_id);
      if (vecs[i].e_cv)
        check($sformatf("v%0d change_amt", i), bus.change_amt, vecs[i].e_amt);
    end

    // Refund the leftover 25 so the next sequence starts from IDLE
    drive(0, 2'd0, 0, 2'd0, 1, 0);
    @(posedge clk); #1;
    drive(0, 2'd0, 0, 2'd0, 0, 1);
    @(posedge clk); #1;
    check("drain credit", bus.credit, 0);

    // Reset during VEND, then a coin on the first edge after release
    drive(1, 2'd3, 0, 2'd0, 0, 0);
    @(posedge clk); #1;
    drive(0, 2'd0, 1, 2'd3, 0, 0);
    @(posedge clk); #1;
    check("vend dispense", bus.dispense, 1);
    check("vend id", bus.dispense_id, 3);
    drive(0, 2'd0, 0, 2'd0, 0, 0);
    rst_n = 1'b0;
    #1 check_all_zero("rst_vend");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2'd2, 0, 2'd0, 0, 0);
    @(posedge clk); #1;
    check("post_rst coin credit", bus.credit, 25);
    check("post_rst dispense", bus.dispense, 0);
    check("post_rst change_valid", bus.change_valid, 0);
    check("post_rst busy", bus.busy, 0);
    drive(0, 2'd0, 0, 2'd0, 0, 0);
    @(posedge clk); #1;
    check("post_rst2 dispense", bus.dispense, 0);
    check("post_rst2 change_valid", bus.change_valid, 0);

    // Reset during CHANGE
    drive(0, 2'd0, 0, 2'd0, 1, 0);
    @(posedge clk); #1;
    check("chg change_valid", bus.change_valid, 1);
    check("chg change_amt", bus.change_amt, 25);
    drive(0, 2'd0, 0, 2'd0, 0, 0);
    rst_n = 1'b0;
    #1 check_all_zero("rst_chg");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_chg change_valid", bus.change_valid, 0);
    check("post_chg credit", bus.credit, 0);
    check("post_chg busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter PRICE_A, default 25, price of item 0 in cents.
REQ-002 Parameter PRICE_B, default 50, price of item 1 in cents.
REQ-003 Parameter PRICE_C, default 75, price of item 2 in cents.
REQ-004 Parameter PRICE_D, default 100, price of item 3 in cents.
REQ-005 Parameter MAX_CREDIT, default 200, highest credit accepted in cents; must be <= 255.
REQ-006 Port clk  input  1  clock; all state changes on the rising edge.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port coin_valid  input  1  coin present this cycle; coin_code is valid while high.
REQ-009 Port coin_code  input  2  coin value: 00=5, 01=10, 10=25, 11=100.
REQ-010 Port sel_valid  input  1  selection request this cycle; sel is valid while high.
REQ-011 Port sel  input  2  item index 0..3, mapped to PRICE_A..PRICE_D.
REQ-012 Port cancel  input  1  refund request.
REQ-013 Port change_ack  input  1  change hopper has taken change_amt.
REQ-014 Port credit  output  8  current credit, registered.
REQ-015 Port coin_reject  output  1  one-cycle pulse; the coin was returned and not credited.
REQ-016 Port price_short  output  1  one-cycle pulse; the selection was refused because credit < price.
REQ-017 Port dispense  output  1  one-cycle pulse; vend the item.
REQ-018 Port dispense_id  output  2  item index; valid while dispense is high.
REQ-019 Port change_valid  output  1  change request; held until acknowledged.
REQ-020 Port change_amt  output  8  change value; stable while change_valid is high.
REQ-021 Port busy  output  1  high in VEND and CHANGE states.

Function
REQ-022 The FSM SHALL use four states: IDLE, CREDIT, VEND, CHANGE.
REQ-023 In IDLE (credit=0), an accepted coin SHALL add its value to credit and move the FSM to CREDIT on the same edge.
REQ-024 In IDLE and CREDIT, a coin SHALL be rejected (coin_reject=1 next cycle, credit unchanged) when credit + value > MAX_CREDIT; the addition SHALL be computed 9-bit wide, so no wrap.
REQ-025 In CREDIT, a sel_valid with credit >= price(sel) SHALL latch sel and move the FSM to VEND.
REQ-026 In CREDIT, a sel_valid with credit < price(sel) SHALL pulse price_short next cycle; state and credit stay unchanged.
REQ-027 In IDLE, a sel_valid SHALL pulse price_short and the FSM SHALL remain in IDLE.
REQ-028 In CREDIT, a cancel SHALL move the FSM to CHANGE with change_amt = credit.
REQ-029 Same-cycle priority SHALL be: cancel > sel_valid > coin_valid.
  - A coin arriving with cancel or sel_valid SHALL be rejected (coin_reject pulse).
  - A sel_valid arriving with cancel SHALL be ignored, with no price_short.
REQ-030 In VEND (exactly one cycle): dispense=1, dispense_id = latched sel, and credit SHALL become credit - price on the exit edge.
  - Exit to CHANGE if the remainder > 0, else to IDLE.
  - Latency: sel_valid edge -> dispense high in the next cycle.
REQ-031 In CHANGE: change_valid=1 and change_amt = credit, held stable.
  - On change_ack: credit=0, change_valid drops next cycle, FSM goes to IDLE.
  - change_ack outside CHANGE SHALL be ignored.
REQ-032 In VEND and CHANGE, every coin SHALL be rejected, and sel_valid and cancel SHALL be ignored.
REQ-033 The pulse outputs (coin_reject, price_short, dispense) SHALL be registered and never high two consecutive cycles for one event.

Reset
REQ-034 rst_n low SHALL immediately force:
  - FSM to IDLE;
  - credit=0, change_amt=0, dispense_id=0;
  - coin_reject, price_short, dispense, change_valid and busy to 0.
REQ-035 Reset asserted mid-VEND or mid-CHANGE SHALL abort the operation; no dispense or change output follows reset release.
REQ-036 After rst_n rises, the block SHALL accept a coin on the first rising edge.

Verification
REQ-037 Exact vend: coins 25 then 25, sel=1 -> credit 50, dispense=1 with id=1 for one cycle, credit=0, IDLE, change_valid stays 0.
REQ-038 Vend with change: coin 100, sel=0 -> dispense id=0, then change_valid=1 with change_amt=75; change_ack -> credit=0, IDLE.
REQ-039 Short credit and overflow:
  - coin 10, sel=3 -> price_short pulse, credit 10.
  - coins 100, 100, then 5 -> third coin rejected, credit 200.
REQ-040 Simultaneous events: in CREDIT with 50, assert cancel+sel_valid+coin_valid in one cycle -> coin_reject pulse, no dispense, change_amt=50.
REQ-041 Busy lockout: during CHANGE, coin 25 and sel_valid -> coin_reject pulse, credit and change_amt unchanged, no dispense.
REQ-042 Reset mid-operation: assert rst_n=0 during VEND -> all outputs 0 immediately; after release, no dispense or change output and credit=0.
